memwb_skid_reg: RTL and testbench

Parametrised MEM/WB pipeline stage for the MIPS pipeline.
- Generalises the fixed MEM/WB latch to configurable data, register-address and control widths.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a stalled write-back port no longer forces combinational stall back into MEM.
- Adds flush (bubble insertion) and valid-gated control decode, plus the write-back data mux.
- Sits between the data-memory stage and the register-file write port / forwarding unit.

---
 rtl/memwb_pkg.sv | 21 ++
 rtl/pipe_skid_buffer.sv | 78 +++++++
 rtl/memwb_skid_reg.sv | 80 ++++++++
 tb/tb_memwb_skid_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared types and constants for the MEM/WB stage and its skid buffer.
package memwb_pkg;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skidState_t;

  // Default positions of the decoded bits inside the MIPS control bundle.
  localparam int DEF_RFWR_BIT    = 23;
  localparam int DEF_MEM2REG_BIT = 0;
  localparam int DEF_MEMR_BIT    = 26;

  // Width of one packed MEM/WB beat: {ctrl, dm, alu, rtd}.
  function automatic int beatWidth(input int cw, input int dw, input int aw);
    return cw + 2 * dw + aw;
  endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry skid buffer with flush. The output always comes from the
// main entry; the skid entry absorbs one beat when the consumer stalls, so
// inReady depends only on registered state and never on outReady.
module pipe_skid_buffer
  import memwb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);

  skidState_t stateReg, stateNext;
  logic [W-1:0] mainReg;
  logic [W-1:0] skidReg;
  logic accept;
  logic drain;

  assign accept  = inValid & inReady;
  assign drain   = outValid & outReady;
  assign outData = mainReg;

  // State register: reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) stateReg <= EMPTY;
    else     stateReg <= stateNext;
  end

  // Next-state decode; flush drops held beats and any beat accepted this cycle.
  always_comb begin
    stateNext = stateReg;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      unique case (stateReg)
        EMPTY:   if (accept) stateNext = ONE;
        ONE: begin
          if (accept && !drain)      stateNext = TWO;
          else if (!accept && drain) stateNext = EMPTY;
        end
        TWO:     if (drain) stateNext = ONE;
        default: stateNext = EMPTY;
      endcase
    end
  end

  // Handshake outputs, decoded from registered state (plus rst for inReady).
  always_comb begin
    outValid = (stateReg != EMPTY);
    inReady  = !rst && (stateReg != TWO);
  end

  // Entry storage: main feeds the output, skid holds the overflow beat.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mainReg <= '0;
      skidReg <= '0;
    end else begin
      unique case (stateReg)
        EMPTY: if (accept) mainReg <= inData;
        ONE: begin
          if (accept && drain) mainReg <= inData;
          else if (accept)     skidReg <= inData;
        end
        TWO:     if (drain) mainReg <= skidReg;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/memwb_skid_reg.sv
// MEM/WB pipeline stage: skid-buffered beat of {ctrl, dm, alu, rtd} with
// valid-gated control decode and the write-back data mux.
module memwb_skid_reg
  import memwb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int CW          = 27,
  parameter int RFWR_BIT    = DEF_RFWR_BIT,
  parameter int MEM2REG_BIT = DEF_MEM2REG_BIT,
  parameter int MEMR_BIT    = DEF_MEMR_BIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] ctrl_in,
  input  logic [DW-1:0] dm_in,
  input  logic [DW-1:0] alu_in,
  input  logic [AW-1:0] rtd_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dm_out,
  output logic [DW-1:0] alu_out,
  output logic [AW-1:0] rtd_out,
  output logic          rf_wr,
  output logic          mem_to_reg,
  output logic          memwb_mem_r,
  output logic [DW-1:0] wb_data
);

  localparam int BW = beatWidth(CW, DW, AW);

  // Refuse to elaborate with control bit indices outside the bundle.
  if (RFWR_BIT < 0 || RFWR_BIT >= CW) begin : gBadRfwr
    $error("memwb_skid_reg: RFWR_BIT out of range");
  end
  if (MEM2REG_BIT < 0 || MEM2REG_BIT >= CW) begin : gBadMem2reg
    $error("memwb_skid_reg: MEM2REG_BIT out of range");
  end
  if (MEMR_BIT < 0 || MEMR_BIT >= CW) begin : gBadMemr
    $error("memwb_skid_reg: MEMR_BIT out of range");
  end

  logic [BW-1:0] inBeat;
  logic [BW-1:0] outBeat;
  logic [CW-1:0] ctrlHeld;
  logic          ctrlUnused;

  assign inBeat = {ctrl_in, dm_in, alu_in, rtd_in};

  pipe_skid_buffer #(
    .W(BW)
  ) uSkid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .inData   (inBeat),
    .outValid (out_valid),
    .outReady (out_ready),
    .outData  (outBeat)
  );

  assign {ctrlHeld, dm_out, alu_out, rtd_out} = outBeat;

  // The full bundle is carried for later WB use; only three bits decode here.
  assign ctrlUnused = ^ctrlHeld;

  // Control decode gated by out_valid so bubbles never write or forward.
  always_comb begin
    rf_wr       = ctrlHeld[RFWR_BIT] & out_valid;
    mem_to_reg  = ctrlHeld[MEM2REG_BIT] & out_valid;
    memwb_mem_r = ctrlHeld[MEMR_BIT] & out_valid;
    wb_data     = mem_to_reg ? dm_out : alu_out;
  end

endmodule

// File: tb/tb_memwb_skid_reg.sv
// Directed table-driven bench for memwb_skid_reg plus hand-written corner cases.
module tb_memwb_skid_reg;

  localparam logic [26:0] C_NONE = 27'h0000000;
  localparam logic [26:0] C_WR   = 27'h0800000;  // rf write only
  localparam logic [26:0] C_LD   = 27'h4800001;  // load: rf write, mem2reg, mem read
  localparam logic [26:0] C_ONES = 27'h7ffffff;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [26:0] ctrl_in;
  logic [31:0] dm_in, alu_in, dm_out, alu_out, wb_data;
  logic [4:0]  rtd_in, rtd_out;
  logic        rf_wr, mem_to_reg, memwb_mem_r;

  always #5 clk = ~clk;

  memwb_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .dm_in(dm_in), .alu_in(alu_in), .rtd_in(rtd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .dm_out(dm_out), .alu_out(alu_out), .rtd_out(rtd_out),
    .rf_wr(rf_wr), .mem_to_reg(mem_to_reg), .memwb_mem_r(memwb_mem_r),
    .wb_data(wb_data)
  );

  typedef struct {
    logic        rst, flush, inV, outR;
    logic [26:0] ctrl;
    logic [31:0] dm, alu;
    logic [4:0]  rtd;
    logic        eInR, eOutV, eRf, eM2r, eMemR, chkData;
    logic [4:0]  eRtd;
    logic [31:0] eWb;
  } vec_t;

  vec_t vecs[$];
  int   passCnt = 0;
  int   totalCnt = 0;

  function automatic vec_t mk(
    input logic r, input logic f, input logic iv, input logic orr,
    input logic [26:0] c, input logic [31:0] d, input logic [31:0] a, input logic [4:0] t,
    input logic eir, input logic eov, input logic erf, input logic em2r, input logic emr,
    input logic cd, input logic [4:0] ert, input logic [31:0] ewb);
    vec_t v;
    v.rst = r; v.flush = f; v.inV = iv; v.outR = orr;
    v.ctrl = c; v.dm = d; v.alu = a; v.rtd = t;
    v.eInR = eir; v.eOutV = eov; v.eRf = erf; v.eM2r = em2r; v.eMemR = emr;
    v.chkData = cd; v.eRtd = ert; v.eWb = ewb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic orr,
                       input logic [26:0] c, input logic [31:0] d, input logic [31:0] a,
                       input logic [4:0] t);
    rst = r; flush = f; in_valid = iv; out_ready = orr;
    ctrl_in = c; dm_in = d; alu_in = a; rtd_in = t;
  endtask

  initial begin
    int sent, received, expQ[$];
    logic acc, drn;
    logic [31:0] expAlu;

    drive(1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 32'h0, 32'h0, 5'd0);

    // rst flush inV outR ctrl dm alu rtd | inR oV rf m2r memr chkData rtd wb
    // 1. reset with in_valid high, then release
    vecs.push_back(mk(1,0,1,1, C_WR, 32'h0, 32'h99, 5'd1,   0,0,0,0,0, 1, 5'd0, 32'h0));
    vecs.push_back(mk(1,0,1,1, C_WR, 32'h0, 32'h99, 5'd1,   0,0,0,0,0, 1, 5'd0, 32'h0));
    vecs.push_back(mk(0,0,0,1, C_NONE, 32'h0, 32'h0, 5'd0,  1,0,0,0,0, 1, 5'd0, 32'h0));
    // 2. streaming at one beat per cycle
    vecs.push_back(mk(0,0,1,1, C_WR, 32'h0, 32'h10, 5'd8,   1,1,1,0,0, 1, 5'd8,  32'h10));
    vecs.push_back(mk(0,0,1,1, C_WR, 32'h0, 32'h11, 5'd9,   1,1,1,0,0, 1, 5'd9,  32'h11));
    vecs.push_back(mk(0,0,1,1, C_WR, 32'h0, 32'h12, 5'd10,  1,1,1,0,0, 1, 5'd10, 32'h12));
    vecs.push_back(mk(0,0,1,1, C_WR, 32'h0, 32'h13, 5'd11,  1,1,1,0,0, 1, 5'd11, 32'h13));
    vecs.push_back(mk(0,0,0,1, C_NONE, 32'h0, 32'h0, 5'd0,  1,0,0,0,0, 0, 5'd0, 32'h0));
    // 3. back-pressure: A, B fill both entries, C refused, then drain in order
    vecs.push_back(mk(0,0,1,0, C_LD, 32'hAAAA0000, 32'h20, 5'd3, 1,1,1,1,1, 1, 5'd3, 32'hAAAA0000));
    vecs.push_back(mk(0,0,1,0, C_WR, 32'hBBBB0000, 32'h21, 5'd4, 0,1,1,1,1, 1, 5'd3, 32'hAAAA0000));
    vecs.push_back(mk(0,0,1,0, C_WR, 32'hCCCC0000, 32'h22, 5'd5, 0,1,1,1,1, 1, 5'd3, 32'hAAAA0000));
    vecs.push_back(mk(0,0,1,1, C_WR, 32'hCCCC0000, 32'h22, 5'd5, 1,1,1,0,0, 1, 5'd4, 32'h21));
    vecs.push_back(mk(0,0,1,1, C_WR, 32'hCCCC0000, 32'h22, 5'd5, 1,1,1,0,0, 1, 5'd5, 32'h22));
    vecs.push_back(mk(0,0,0,1, C_NONE, 32'h0, 32'h0, 5'd0,       1,0,0,0,0, 0, 5'd0, 32'h0));
    // 4. flush while full, with an incoming beat on the flush cycle
    vecs.push_back(mk(0,0,1,0, C_LD, 32'h11110000, 32'h30, 5'd6, 1,1,1,1,1, 1, 5'd6, 32'h11110000));
    vecs.push_back(mk(0,0,1,0, C_WR, 32'h22220000, 32'h31, 5'd7, 0,1,1,1,1, 1, 5'd6, 32'h11110000));
    vecs.push_back(mk(0,1,1,0, C_LD, 32'h33330000, 32'h32, 5'd9, 1,0,0,0,0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0,0,0,1, C_NONE, 32'h0, 32'h0, 5'd0,       1,0,0,0,0, 0, 5'd0, 32'h0));
    // 5. bubbles with an all-ones control bundle
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,0,1, C_ONES, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1,0,0,0,0, 0, 5'd0, 32'h0));
    // 6. reset while full, then one lone beat
    vecs.push_back(mk(0,0,1,0, C_WR, 32'h0, 32'h40, 5'd12, 1,1,1,0,0, 1, 5'd12, 32'h40));
    vecs.push_back(mk(0,0,1,0, C_WR, 32'h0, 32'h41, 5'd13, 0,1,1,0,0, 1, 5'd12, 32'h40));
    vecs.push_back(mk(1,0,1,0, C_WR, 32'h0, 32'h42, 5'd15, 0,0,0,0,0, 1, 5'd0,  32'h0));
    vecs.push_back(mk(0,0,1,0, C_LD, 32'h12345678, 32'h50, 5'd14, 1,1,1,1,1, 1, 5'd14, 32'h12345678));
    vecs.push_back(mk(0,0,0,1, C_NONE, 32'h0, 32'h0, 5'd0,   1,0,0,0,0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0,0,0,1, C_NONE, 32'h0, 32'h0, 5'd0,   1,0,0,0,0, 0, 5'd0, 32'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].flush, vecs[i].inV, vecs[i].outR,
            vecs[i].ctrl, vecs[i].dm, vecs[i].alu, vecs[i].rtd);
      @(posedge clk);
      #1;
      $display("vec %0d: rst=%0b flush=%0b in_valid=%0b out_ready=%0b -> in_ready=%0b out_valid=%0b rf_wr=%0b m2r=%0b memr=%0b rtd=%0d wb=%h",
               i, rst, flush, in_valid, out_ready, in_ready, out_valid, rf_wr, mem_to_reg,
               memwb_mem_r, rtd_out, wb_data);
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].eInR});
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eOutV});
      chk($sformatf("v%0d rf_wr", i), {31'b0, rf_wr}, {31'b0, vecs[i].eRf});
      chk($sformatf("v%0d mem_to_reg", i), {31'b0, mem_to_reg}, {31'b0, vecs[i].eM2r});
      chk($sformatf("v%0d memwb_mem_r", i), {31'b0, memwb_mem_r}, {31'b0, vecs[i].eMemR});
      if (vecs[i].chkData) begin
        chk($sformatf("v%0d rtd_out", i), {27'b0, rtd_out}, {27'b0, vecs[i].eRtd});
        chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].eWb);
      end
    end

    // in_ready drops combinationally with rst, and returns after release
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1, C_WR, 32'h0, 32'h77, 5'd2);
    #1;
    $display("hand: rst high -> in_ready=%0b", in_ready);
    chk("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 32'h0, 32'h0, 5'd0);
    #1;
    $display("hand: rst released -> in_ready=%0b out_valid=%0b", in_ready, out_valid);
    chk("rel_in_ready_high", {31'b0, in_ready}, 32'd1);
    chk("rel_out_valid_low", {31'b0, out_valid}, 32'd0);

    // FIFO ordering under irregular back-pressure, checked with a scoreboard
    sent = 0;
    received = 0;
    for (int cyc = 0; cyc < 80 && received < 10; cyc++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, sent < 10, (cyc % 3) != 0, C_WR, 32'h0,
            32'h100 + sent, 5'(sent));
      #1;
      acc = in_valid & in_ready;
      drn = out_valid & out_ready;
      if (drn) begin
        if (expQ.size() == 0) begin
          chk("sb_unexpected_beat", alu_out, 32'hDEAD_BEEF);
        end else begin
          expAlu = 32'(expQ.pop_front());
          $display("sb: drain alu=%h rtd=%0d (want alu=%h)", alu_out, rtd_out, expAlu);
          chk("sb_alu", alu_out, expAlu);
          chk("sb_rtd", {27'b0, rtd_out}, {27'b0, expAlu[4:0]});
          chk("sb_rf_wr", {31'b0, rf_wr}, 32'd1);
        end
        received++;
      end
      if (acc) begin
        expQ.push_back(32'h100 + sent);
        sent++;
      end
    end
    chk("sb_received", received, 32'd10);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
